oqpsk_iq_mapper: RTL

Downstream consumer of the TX FIFO serial stream. Requests bits with `en_IQ`, captures each bit on the rising edge of the FIFO's `IQ_rate` strobe, and demultiplexes alternate bits onto the I and Q branches. Each branch emits a signed pulse two bit-periods long. The Q branch is therefore offset by one bit period, which yields the IEEE 802.15.4 O-QPSK baseband sample stream for the DAC/upconversion stage at system clock rate.

---
 rtl/oqpsk_iq_mapper.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/oqpsk_iq_mapper.sv
// O-QPSK I/Q mapper: captures serial bits on strobe rising edges, alternates them onto I/Q
// branches as two-bit-period pulses. Define OQPSK_SHAPING_EN for half-sine shaping.
module oqpsk_iq_mapper #(
  parameter int SAMPLE_W    = 8,
  parameter int HALF_PERIOD = 25
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tx_en,
  input  logic                       mem_state,
  input  logic                       bit_in,
  input  logic                       bit_strobe,
  output logic                       en_IQ,
  output logic signed [SAMPLE_W-1:0] i_out,
  output logic signed [SAMPLE_W-1:0] q_out,
  output logic                       iq_valid,
  output logic                       busy
);
  // state | meaning
  // IDLE  | waiting for tx_en with a non-empty FIFO
  // RUN   | requesting and capturing bits, pulses launched per capture
  // DRAIN | no new captures, in-flight pulses finish
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int P    = 2 * HALF_PERIOD;
  localparam int PH_W = $clog2(P);
  localparam logic [SAMPLE_W-1:0] AMP = {1'b0, {(SAMPLE_W-1){1'b1}}};

`ifdef OQPSK_SHAPING_EN
  function automatic int lut_entry(input int k);
    real x;
    x = real'((2 ** (SAMPLE_W-1)) - 1) * $sin(3.14159265358979 * real'(k) / real'(P));
    return $rtoi(x + 0.5);
  endfunction

  logic [SAMPLE_W-1:0] lut [P];
  for (genvar k = 0; k < P; k++) begin : g_lut
    assign lut[k] = SAMPLE_W'(lut_entry(k));
  end
`endif

  state_t              state_q, state_d;
  logic                parity_q, parity_d;
  logic                strobe_prev_q, strobe_prev_d;
  logic [PH_W-1:0]     tmo_q, tmo_d;
  logic [1:0]          active_q, active_d;
  logic [1:0]          sign_q, sign_d;
  logic [PH_W-1:0]     phase_q [2];
  logic [PH_W-1:0]     phase_d [2];
  logic [SAMPLE_W-1:0] mag_v [2];
  logic [SAMPLE_W-1:0] samp_d [2];
  logic [SAMPLE_W-1:0] i_out_q, q_out_q;
  logic                en_iq_q, en_iq_d;
  logic                iq_valid_q, iq_valid_d;
  logic                busy_q, busy_d;
  logic                capture;

  always_comb begin
    state_d       = state_q;
    parity_d      = parity_q;
    tmo_d         = tmo_q;
    active_d      = active_q;
    sign_d        = sign_q;
    phase_d       = phase_q;
    strobe_prev_d = bit_strobe;
    capture       = bit_strobe && !strobe_prev_q && (state_q == RUN);

    case (state_q)
      IDLE: begin
        parity_d = 1'b0;
        if (tx_en && mem_state) begin
          state_d = RUN;
          tmo_d   = PH_W'(P-1);
        end
      end
      RUN: begin
        // timeout is a down-counter reloaded on every capture; zero means P idle clocks
        if (capture) begin
          parity_d = ~parity_q;
          tmo_d    = PH_W'(P-1);
        end else if (tmo_q != '0) begin
          tmo_d = tmo_q - 1'b1;
        end
        if (!tx_en || (!capture && tmo_q == '0)) state_d = DRAIN;
      end
      DRAIN: begin
        if (active_q == 2'b00) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    for (int b = 0; b < 2; b++) begin
      if (active_q[b]) begin
        if (phase_q[b] == PH_W'(P-1)) active_d[b] = 1'b0;
        else                          phase_d[b]  = phase_q[b] + 1'b1;
      end
      // a capture restarts the branch even mid-pulse; that is the nominal abutting case
      if (capture && (int'(parity_q) == b)) begin
        sign_d[b]   = bit_in;
        phase_d[b]  = '0;
        active_d[b] = 1'b1;
      end
`ifdef OQPSK_SHAPING_EN
      mag_v[b] = lut[phase_d[b]];
`else
      mag_v[b] = AMP;
`endif
      samp_d[b] = active_d[b] ? (sign_d[b] ? mag_v[b] : -mag_v[b]) : '0;
    end

    en_iq_d    = (state_d == RUN);
    iq_valid_d = (state_d != IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      parity_q      <= 1'b0;
      strobe_prev_q <= 1'b0;
      tmo_q         <= '0;
      active_q      <= 2'b00;
      sign_q        <= 2'b00;
      phase_q       <= '{default: '0};
      i_out_q       <= '0;
      q_out_q       <= '0;
      en_iq_q       <= 1'b0;
      iq_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      parity_q      <= parity_d;
      strobe_prev_q <= strobe_prev_d;
      tmo_q         <= tmo_d;
      active_q      <= active_d;
      sign_q        <= sign_d;
      phase_q       <= phase_d;
      i_out_q       <= samp_d[0];
      q_out_q       <= samp_d[1];
      en_iq_q       <= en_iq_d;
      iq_valid_q    <= iq_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign en_IQ    = en_iq_q;
  assign i_out    = $signed(i_out_q);
  assign q_out    = $signed(q_out_q);
  assign iq_valid = iq_valid_q;
  assign busy     = busy_q;

endmodule
